// File: rtl/lsu_subword.sv
// Load/store alignment unit between the MEM stage and a word-only, synchronous-read data memory.
// Sub-word stores use read-modify-write; loads are lane-selected and sign/zero extended.
module lsu_subword #(
  parameter bit MISALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err_o,
  output logic [31:0] mem_ad,
  output logic [31:0] wrtDat,
  output logic        memWrt,
  input  logic [31:0] redDat
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD_WAIT = 2'd1;
  localparam logic [1:0] S_RMW_MERGE = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]  r_state;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_err;

  logic        w_ready;
  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_bad;
  logic        w_sw_now;

  // Halfwords are located by addr[1] alone, so force-aligned halves need no extra handling.
  function automatic logic [31:0] f_load_ext(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    logic [31:0] v_res;
    v_b = word[{off, 3'b000} +: 8];
    v_h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    v_res = {{24{v_b[7]}}, v_b};
      F3_BU:   v_res = {24'h000000, v_b};
      F3_H:    v_res = {{16{v_h[15]}}, v_h};
      F3_HU:   v_res = {16'h0000, v_h};
      default: v_res = word;
    endcase
    return v_res;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] word,
                                          input logic [31:0] wd,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  off);
    logic [31:0] v_res;
    v_res = word;
    case (f3)
      F3_B:    v_res[{off, 3'b000} +: 8] = wd[7:0];
      F3_H:    v_res[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: v_res = word;
    endcase
    return v_res;
  endfunction

  assign w_ready  = (r_state == S_IDLE) && !rst;
  assign w_accept = req_valid && w_ready;

  // Request classification: illegal encodings and size misalignment.
  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    if (req_we) begin
      case (req_funct3)
        F3_B, F3_H, F3_W: w_illegal = 1'b0;
        default:          w_illegal = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: w_illegal = 1'b0;
        default:                        w_illegal = 1'b1;
      endcase
    end
    if (MISALIGN_CHK) begin
      case (req_funct3)
        F3_H, F3_HU: w_misalign = req_addr[0];
        F3_W:        w_misalign = (req_addr[1:0] != 2'b00);
        default:     w_misalign = 1'b0;
      endcase
    end else begin
      w_misalign = 1'b0;
    end
  end

  assign w_bad    = w_illegal || w_misalign;
  assign w_sw_now = w_accept && !w_bad && req_we && (req_funct3 == F3_W);

  // Memory-side drive: SW goes straight through, sub-word stores write back the merged word.
  always_comb begin
    mem_ad = {r_addr[31:2], 2'b00};
    memWrt = 1'b0;
    wrtDat = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        mem_ad = {req_addr[31:2], 2'b00};
        if (w_sw_now) begin
          memWrt = 1'b1;
          wrtDat = req_wdata;
        end else begin
          memWrt = 1'b0;
          wrtDat = 32'h0000_0000;
        end
      end
      S_RMW_MERGE: begin
        if (!rst) begin
          memWrt = 1'b1;
          wrtDat = f_merge(redDat, r_wdata, r_f3, r_addr[1:0]);
        end else begin
          memWrt = 1'b0;
          wrtDat = 32'h0000_0000;
        end
      end
      default: begin
        memWrt = 1'b0;
        wrtDat = 32'h0000_0000;
      end
    endcase
  end

  // Sequencer, request latches and registered response/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_f3        <= 3'b000;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_bad) begin
              r_err <= 1'b1;
            end else if (!req_we) begin
              r_state <= S_LOAD_WAIT;
            end else if (req_funct3 != F3_W) begin
              r_state <= S_RMW_MERGE;
            end
          end
        end
        S_LOAD_WAIT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= f_load_ext(redDat, r_f3, r_addr[1:0]);
          r_state     <= S_IDLE;
        end
        S_RMW_MERGE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign err_o     = r_err;

endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword with a byte-addressed reference memory model and
// a per-cycle compare process for rsp_valid/rsp_rdata/err_o.
module tb_lsu_subword;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err_o;
  logic [31:0] mem_ad;
  logic [31:0] wrtDat;
  logic        memWrt;
  logic [31:0] redDat;

  lsu_subword #(.MISALIGN_CHK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err_o(err_o),
    .mem_ad(mem_ad), .wrtDat(wrtDat), .memWrt(memWrt), .redDat(redDat)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int w18_cnt = 0;

  logic [31:0] mem [0:63];
  logic [7:0]  mdl [0:255];
  bit          exp_err [int];
  logic [31:0] exp_rsp [int];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Synchronous-read word memory: read of the presented address returns next cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    redDat <= mem[mem_ad[7:2]];
    if (memWrt) begin
      mem[mem_ad[7:2]] <= wrtDat;
      wr_cnt <= wr_cnt + 1;
      if (mem_ad == 32'h0000_0018) w18_cnt <= w18_cnt + 1;
    end
  end

  // Compare response/error outputs against model expectations every cycle
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("err_o", {31'd0, err_o}, {31'd0, exp_err.exists(cyc)});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp.exists(cyc)});
      if (exp_rsp.exists(cyc)) check("rsp_rdata", rsp_rdata, exp_rsp[cyc]);
    end
  end

  // Model of one accepted request, called just before the accepting clock edge
  task automatic model_accept();
    int size;
    int a;
    bit ill;
    bit mis;
    logic [31:0] v;
    size = (req_funct3[1:0] == 2'd0) ? 1 : ((req_funct3[1:0] == 2'd1) ? 2 : 4);
    a = int'(req_addr[7:0]);
    if (req_we) ill = !(req_funct3 inside {3'd0, 3'd1, 3'd2});
    else        ill = !(req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = (a % size) != 0;
    if (ill || mis) begin
      exp_err[cyc + 1] = 1'b1;
    end else if (req_we) begin
      for (int i = 0; i < size; i++) mdl[a + i] = req_wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[a + i];
      if (!req_funct3[2] && size < 4 && v[8*size-1])
        v = v | ~((32'd1 << (8*size)) - 32'd1);
      exp_rsp[cyc + 2] = v;
    end
  endtask

  task automatic present(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int waits);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    waits = 0;
    #1;
    while (!req_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic accept();
    model_accept();
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic load_lit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    int w;
    present(1'b0, f3, a, 32'h0, w);
    accept();
    check("load_lat_wait", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("load_lat_valid", {31'd0, rsp_valid}, 32'd1);
    check("load_value", rsp_rdata, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    int save_wr;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_memWrt", {31'd0, memWrt}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // SW goes out in the accepting cycle
    present(1'b1, 3'b010, 32'h10, 32'h80007F80, w);
    check("sw_memWrt", {31'd0, memWrt}, 32'd1);
    check("sw_mem_ad", mem_ad, 32'h10);
    check("sw_wrtDat", wrtDat, 32'h80007F80);
    accept();
    check("sw_ready_after", {31'd0, req_ready}, 32'd1);

    load_lit(3'b000, 32'h10, 32'hFFFFFF80);
    load_lit(3'b100, 32'h11, 32'h0000007F);
    load_lit(3'b001, 32'h12, 32'hFFFF8000);
    load_lit(3'b101, 32'h12, 32'h00008000);

    // SB read-modify-write
    present(1'b1, 3'b000, 32'h13, 32'h123456AA, w);
    check("sb_c0_memWrt", {31'd0, memWrt}, 32'd0);
    accept();
    check("sb_c1_ready", {31'd0, req_ready}, 32'd0);
    check("sb_c1_memWrt", {31'd0, memWrt}, 32'd1);
    check("sb_c1_wrtDat", wrtDat, 32'hAA007F80);
    check("sb_c1_mem_ad", mem_ad, 32'h10);
    load_lit(3'b010, 32'h10, 32'hAA007F80);

    // SH into the upper half of an all-zero word
    present(1'b1, 3'b001, 32'h16, 32'h0000BEEF, w);
    accept();
    check("sh_wrtDat", wrtDat, 32'hBEEF0000);
    load_lit(3'b010, 32'h14, 32'hBEEF0000);

    // Error cases
    save_wr = wr_cnt;
    present(1'b1, 3'b001, 32'h11, 32'h00001234, w);
    check("sh_mis_memWrt", {31'd0, memWrt}, 32'd0);
    accept();
    check("sh_mis_err", {31'd0, err_o}, 32'd1);
    check("sh_mis_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    present(1'b0, 3'b010, 32'h12, 32'h0, w);
    accept();
    check("lw_mis_err", {31'd0, err_o}, 32'd1);
    @(posedge clk); #1;
    present(1'b0, 3'b011, 32'h10, 32'h0, w);
    accept();
    check("ld011_err", {31'd0, err_o}, 32'd1);
    @(posedge clk); #1;
    check("err_no_write", wr_cnt, save_wr);
    load_lit(3'b010, 32'h10, 32'hAA007F80);

    // Reset during RMW_MERGE abandons the store
    save_wr = wr_cnt;
    present(1'b1, 3'b000, 32'h10, 32'h00000055, w);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rmw_rst_memWrt", {31'd0, memWrt}, 32'd0);
    check("rmw_rst_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rmw_rst_release_ready", {31'd0, req_ready}, 32'd1);
    check("rmw_rst_no_write", wr_cnt, save_wr);
    load_lit(3'b010, 32'h10, 32'hAA007F80);

    // Store held behind an outstanding load
    present(1'b0, 3'b010, 32'h10, 32'h0, w);
    accept();
    present(1'b1, 3'b010, 32'h18, 32'h11223344, w);
    check("b2b_wait_cycles", w, 32'd1);
    check("b2b_sw_memWrt", {31'd0, memWrt}, 32'd1);
    accept();
    @(posedge clk); #1;
    check("b2b_sw_once", w18_cnt, 32'd1);
    load_lit(3'b010, 32'h18, 32'h11223344);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store alignment unit between the MEM-stage pipeline register and the word-only, synchronous-read data memory.
- The data memory has a registered read with one-cycle latency, word addressing via address bits [31:2], and only full-word writes.
- This block converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses, and performs sign/zero extension on loads.
- It uses a read-modify-write sequence for SB/SH, and flags misaligned or illegal requests.

Parameters:
- MISALIGN_CHK, default 1: 1 = misaligned requests raise err_o and issue no access; 0 = low address bits beyond the access size are ignored and the access is force-aligned.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request; 1 only in IDLE and not in rst
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle pulse; rsp_rdata valid
- rsp_rdata  output  32  extended load result
- err_o  output  1  one-cycle pulse; misaligned or illegal request
- mem_ad  output  32  to data memory address
- wrtDat  output  32  to data memory write data
- memWrt  output  1  to data memory write enable
- redDat  input  32  from data memory; valid the cycle after a read is issued

Behaviour:
- States: IDLE, LOAD_WAIT, RMW_MERGE. A request is accepted when req_valid && req_ready. Requests presented while req_ready=0 are ignored; upstream holds them.
- Memory-side outputs are combinational from state, request inputs and latched fields:
  - mem_ad = {addr[31:2],2'b00}.
  - In IDLE, mem_ad comes from req_addr. In the other states it comes from the latched address.
  - When memWrt=0, wrtDat=0.
- Illegal encodings: loads with funct3 011/110/111; stores with funct3 other than 000/001/010.
- Misaligned (MISALIGN_CHK=1): H/HU with addr[0]=1; W with addr[1:0]!=0.
- Accept of an illegal or misaligned request:
  - memWrt=0.
  - err_o pulses on the next cycle.
  - rsp_valid stays 0.
  - State stays IDLE.
- Load accept:
  - Read is issued (memWrt=0).
  - Latch funct3 and addr[1:0]; go to LOAD_WAIT.
  - In LOAD_WAIT: select the byte/half by latched addr[1:0] from redDat, then sign-extend (B/H) or zero-extend (BU/HU).
  - Register the result: rsp_valid=1 and rsp_rdata on the cycle after LOAD_WAIT, then return to IDLE.
  - Accept-to-rsp_valid latency is 2 cycles. req_ready=0 in LOAD_WAIT.
- SW accept:
  - memWrt=1 and wrtDat=req_wdata in the same cycle.
  - Stay in IDLE. No stall, no rsp_valid.
- SB/SH accept:
  - Issue a read of the containing word.
  - Latch addr, funct3 and wdata; go to RMW_MERGE.
- In RMW_MERGE:
  - merged = redDat with lane(s) replaced by wdata[7:0] (byte lane addr[1:0]) or wdata[15:0] (half lane addr[1]).
  - Drive memWrt=1, wrtDat=merged, mem_ad=latched word address.
  - Go to IDLE. req_ready=0.
  - Total occupancy is 2 cycles.
- Reset (rst=1):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, err_o=0.
  - memWrt forced 0 and req_ready=0 regardless of inputs.
  - Reset in LOAD_WAIT or RMW_MERGE abandons the operation. No write is issued and no response is produced.
- redDat is ignored except in LOAD_WAIT and RMW_MERGE. It is undefined after a write or during reset.
- MISALIGN_CHK=0: H uses addr[1], W ignores addr[1:0], and err_o is raised only for illegal funct3.

Test Plan:
- Store and sub-word loads:
  - After reset, SW addr 0x10 data 0x80007F80 -> same cycle memWrt=1, mem_ad=0x10, wrtDat=0x80007F80; req_ready stays 1.
  - LB 0x10 -> rsp_rdata 0xFFFFFF80.
  - LBU 0x11 -> 0x0000007F.
  - LH 0x12 -> 0xFFFF8000.
  - LHU 0x12 -> 0x00008000.
  - Each rsp_valid arrives 2 cycles after accept.
- SB 0x13 wdata 0x123456AA on the word above:
  - Cycle 0: memWrt=0.
  - Cycle 1: req_ready=0, memWrt=1, wrtDat=0xAA007F80.
  - A following LW 0x10 -> 0xAA007F80.
- SH 0x16 wdata 0xBEEF over word 0x14=0 -> write 0xBEEF0000. LW 0x14 confirms.
- Error cases:
  - SH 0x11 -> err_o pulse next cycle; memWrt never 1; rsp_valid=0; word 0x10 unchanged.
  - LW 0x12 -> err_o.
  - Load funct3=011 -> err_o.
- Reset mid-operation:
  - Assert rst in the RMW_MERGE cycle of SB 0x10 -> memWrt=0, next state IDLE, no rsp.
  - After release, req_ready=1.
- Back-to-back requests:
  - LW 0x10 accepted, then SW held with req_valid=1 during LOAD_WAIT -> SW accepted only after req_ready returns to 1.
  - Load result is correct and the store is executed exactly once.
